vga_seg_display: RTL and testbench

Parametrised multi-digit seven-segment renderer for the VGA pixel path. It sits between the VGA timing counters and the RGB output mux. It draws DIGITS glyphs as thick-bar seven-segment characters at a fixed screen origin. Displayed values, leading-zero blanking and per-digit blink enables are captured once per frame so no digit tears mid-frame, and the colour output is registered with fixed 2-cycle latency.

---
 rtl/vga_seg_pkg.sv | 18 +
 rtl/vga_seg_glyph.sv | 32 +++
 rtl/vga_seg_display.sv | 187 ++++++++++++++++++
 tb/tb_vga_seg_display.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/vga_seg_pkg.sv
// rtl/vga_seg_pkg.sv - shared constants and types for the seven-segment VGA renderer
// Purpose: glyph code constants, segment bit indices (a..g = bit 0..6), RGB444 type.
package vga_seg_pkg;

    localparam logic [3:0] GLYPH_MINUS = 4'd10;
    localparam logic [3:0] GLYPH_BLANK = 4'd15;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    typedef logic [11:0] rgb444_t;

endpackage

// File: rtl/vga_seg_glyph.sv
// rtl/vga_seg_glyph.sv - glyph code to seven-segment mask decoder
// Purpose: combinational 4-bit glyph code -> 7-bit segment mask (bit SEG_A..SEG_G).
// Ports:
//   i_code  glyph code (0-9 digits, 10 minus, 11-15 blank)
//   o_seg   segment mask, bit n set = segment n lit
module vga_seg_glyph
    import vga_seg_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_seg
);

    // Constants below are written g..a from MSB to LSB.
    always_comb begin
        o_seg = 7'h00;
        case (i_code)
            4'd0:        o_seg = 7'h3F;
            4'd1:        o_seg = 7'h06;
            4'd2:        o_seg = 7'h5B;
            4'd3:        o_seg = 7'h4F;
            4'd4:        o_seg = 7'h66;
            4'd5:        o_seg = 7'h6D;
            4'd6:        o_seg = 7'h7D;
            4'd7:        o_seg = 7'h07;
            4'd8:        o_seg = 7'h7F;
            4'd9:        o_seg = 7'h67;
            GLYPH_MINUS: o_seg[SEG_G] = 1'b1;
            default:     o_seg = 7'h00;
        endcase
    end

endmodule

// File: rtl/vga_seg_display.sv
// rtl/vga_seg_display.sv - multi-digit seven-segment renderer for the VGA pixel path
// Purpose: draws DIGITS thick-bar glyphs at (X0, Y0); frame-latched value, leading-zero
// blanking and blink; registered colour output with 2-cycle latency.
// Ports:
//   i_clk, i_rst          pixel clock, synchronous active-high reset
//   i_h_cnt, i_v_cnt      current pixel column / row
//   i_valid               active video area
//   i_frame_start         one-cycle pulse per frame (vertical blank)
//   i_value               glyph codes, digit 0 in the most significant nibble
//   i_fg, i_bg            lit-segment and background colours (RGB444)
//   i_blank_lz            leading-zero blanking enable
//   i_blink_en            per-digit blink enable, bit k -> digit k
//   o_pixel_out, o_hit    registered colour and lit-segment flag
module vga_seg_display
    import vga_seg_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int SEG_LEN      = 16,
    parameter int SEG_W        = 4,
    parameter int GAP          = 8,
    parameter int X0           = 100,
    parameter int Y0           = 100,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [9:0]            i_h_cnt,
    input  logic [9:0]            i_v_cnt,
    input  logic                  i_valid,
    input  logic                  i_frame_start,
    input  logic [4*DIGITS-1:0]   i_value,
    input  rgb444_t               i_fg,
    input  rgb444_t               i_bg,
    input  logic                  i_blank_lz,
    input  logic [DIGITS-1:0]     i_blink_en,
    output rgb444_t               o_pixel_out,
    output logic                  o_hit
);

    localparam int CW    = SEG_LEN + 2*SEG_W;
    localparam int CH    = 2*SEG_LEN + 3*SEG_W;
    localparam int PITCH = CW + GAP;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [9:0] L_LO    = 10'(SEG_W);
    localparam logic [9:0] L_HI    = 10'(SEG_W + SEG_LEN);
    localparam logic [9:0] L_G_HI  = 10'(SEG_LEN + 2*SEG_W);
    localparam logic [9:0] L_YL_LO = 10'(2*SEG_W + SEG_LEN);
    localparam logic [9:0] L_YL_HI = 10'(2*SEG_W + 2*SEG_LEN);

    // ---------------- shadow registers and blink state ----------------
    logic [4*DIGITS-1:0] r_value;
    logic                r_blank_lz;
    logic [DIGITS-1:0]   r_blink_en;
    logic [CNT_W-1:0]    r_frame_cnt;
    logic                r_phase;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_value     <= '1;
            r_blank_lz  <= 1'b0;
            r_blink_en  <= '0;
            r_frame_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (i_frame_start) begin
            r_value    <= i_value;
            r_blank_lz <= i_blank_lz;
            r_blink_en <= i_blink_en;
            if (r_frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                r_frame_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    // ---------------- stage 1: cell lookup and segment regions ----------------
    logic             w_in_y;
    logic             w_in_cell;
    logic [IDX_W-1:0] w_cell;
    logic [9:0]       w_lx;
    logic [9:0]       w_ly;
    logic             w_xm;
    logic             w_yu;
    logic             w_yl;
    logic [6:0]       w_region;

    assign w_in_y = (i_v_cnt >= 10'(Y0)) && (i_v_cnt < 10'(Y0 + CH));
    assign w_ly   = i_v_cnt - 10'(Y0);

    // Cells are disjoint, so at most one iteration matches.
    always_comb begin
        w_in_cell = 1'b0;
        w_cell    = '0;
        w_lx      = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if ((i_h_cnt >= 10'(X0 + k*PITCH)) && (i_h_cnt < 10'(X0 + k*PITCH + CW))) begin
                w_in_cell = w_in_y;
                w_cell    = IDX_W'(k);
                w_lx      = i_h_cnt - 10'(X0 + k*PITCH);
            end
        end
    end

    assign w_xm = (w_lx >= L_LO) && (w_lx < L_HI);
    assign w_yu = (w_ly >= L_LO) && (w_ly < L_HI);
    assign w_yl = (w_ly >= L_YL_LO) && (w_ly < L_YL_HI);

    // Corner squares fall outside both XM and YU/YL, so they stay dark.
    always_comb begin
        w_region        = '0;
        w_region[SEG_A] = (w_ly < L_LO) && w_xm;
        w_region[SEG_G] = (w_ly >= L_HI) && (w_ly < L_G_HI) && w_xm;
        w_region[SEG_D] = (w_ly >= L_YL_HI) && w_xm;
        w_region[SEG_F] = (w_lx < L_LO) && w_yu;
        w_region[SEG_B] = (w_lx >= L_HI) && w_yu;
        w_region[SEG_E] = (w_lx < L_LO) && w_yl;
        w_region[SEG_C] = (w_lx >= L_HI) && w_yl;
    end

    logic             r_s1_valid;
    logic             r_s1_in_cell;
    logic [IDX_W-1:0] r_s1_cell;
    logic [6:0]       r_s1_region;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_in_cell <= 1'b0;
            r_s1_cell    <= '0;
            r_s1_region  <= '0;
        end else begin
            r_s1_valid   <= i_valid;
            r_s1_in_cell <= w_in_cell;
            r_s1_cell    <= w_cell;
            r_s1_region  <= w_region;
        end
    end

    // ---------------- per-digit blanking from shadow state ----------------
    logic [3:0]        w_codes [DIGITS];
    logic [DIGITS-1:0] w_dig_blank;

    always_comb begin
        logic v_zero_run;
        v_zero_run  = 1'b1;
        w_dig_blank = '0;
        for (int k = 0; k < DIGITS; k++) begin
            w_codes[k] = r_value[4*(DIGITS-1-k) +: 4];
            // Run of leading zeros ends at the first non-zero code (minus/blank included);
            // the rightmost digit always shows.
            v_zero_run = v_zero_run && (w_codes[k] == 4'd0);
            w_dig_blank[k] = (r_blank_lz && v_zero_run && (k < DIGITS - 1))
                           || (!r_phase && r_blink_en[k]);
        end
    end

    // ---------------- stage 2: glyph mask and colour ----------------
    logic [3:0] w_cur_code;
    logic [6:0] w_glyph;
    logic       w_lit;

    assign w_cur_code = w_codes[r_s1_cell];

    vga_seg_glyph u_glyph (
        .i_code (w_cur_code),
        .o_seg  (w_glyph)
    );

    assign w_lit = r_s1_in_cell && !w_dig_blank[r_s1_cell] && (|(w_glyph & r_s1_region));

    always_ff @(posedge i_clk) begin
        if (i_rst || !r_s1_valid) begin
            o_pixel_out <= '0;
            o_hit       <= 1'b0;
        end else if (w_lit) begin
            o_pixel_out <= i_fg;
            o_hit       <= 1'b1;
        end else begin
            o_pixel_out <= i_bg;
            o_hit       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_seg_display.sv
// tb/tb_vga_seg_display.sv - directed self-checking bench for vga_seg_display
module tb_vga_seg_display;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  h_cnt, v_cnt;
    logic        valid, frame_start;
    logic [15:0] value;
    logic [11:0] fg, bg;
    logic        blank_lz;
    logic [3:0]  blink_en;
    logic [11:0] pixel_out;
    logic        hit;

    always #5 clk = ~clk;

    vga_seg_display #(.BLINK_FRAMES(2)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_h_cnt       (h_cnt),
        .i_v_cnt       (v_cnt),
        .i_valid       (valid),
        .i_frame_start (frame_start),
        .i_value       (value),
        .i_fg          (fg),
        .i_bg          (bg),
        .i_blank_lz    (blank_lz),
        .i_blink_en    (blink_en),
        .o_pixel_out   (pixel_out),
        .o_hit         (hit)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Drive one pixel, check {hit, pixel_out} two edges later.
    task automatic expect_px(input string tag, input int h, input int v, input logic lit);
        h_cnt = 10'(h);
        v_cnt = 10'(v);
        valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        @(posedge clk); #1;
        check(tag, {19'd0, hit, pixel_out}, lit ? {19'd0, 1'b1, fg} : {19'd0, 1'b0, bg});
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    // Probe points in cell-local coordinates, order a..g.
    int px [7] = '{10, 22, 22, 10,  1,  1, 10};
    int py [7] = '{ 1, 10, 30, 42, 30, 10, 21};
    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h67, 7'h40, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    logic       blink_vis [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        rst = 1'b1; frame_start = 1'b0; valid = 1'b0; h_cnt = '0; v_cnt = '0;
        value = 16'h8888; blank_lz = 1'b0; blink_en = 4'b0000;
        fg = 12'hF00; bg = 12'h00F;

        // Reset: outputs held at 0, frame_start ignored
        h_cnt = 10'd110; v_cnt = 10'd101; valid = 1'b1;
        repeat (3) begin
            frame_start = 1'b1;
            @(posedge clk); #1;
            check("rst_out", {20'd0, hit, pixel_out}, 32'd0);
        end
        frame_start = 1'b0;
        rst = 1'b0;
        h_cnt = 10'd104; v_cnt = 10'd100;
        @(posedge clk); #1;
        valid = 1'b0;
        check("rst_hold", {20'd0, hit, pixel_out}, 32'd0);
        @(posedge clk); #1;
        check("rst_release_bg", {20'd0, hit, pixel_out}, {20'd0, 1'b0, 12'h00F});
        expect_px("rst_blank_until_fs", 110, 101, 1'b0);

        // Glyph sweep on digit 3 (x base 196)
        for (int code = 0; code < 16; code++) begin
            value = {12'hFFF, 4'(code)};
            pulse_fs();
            for (int s = 0; s < 7; s++)
                expect_px($sformatf("sweep_c%0d_s%0d", code, s), 196 + px[s], 100 + py[s], seg_tab[code][s]);
            expect_px($sformatf("sweep_c%0d_corner", code), 196, 100, 1'b0);
        end

        // Leading-zero blanking
        value = 16'h0040; blank_lz = 1'b1;
        pulse_fs();
        expect_px("lz_d0_blank",  110, 101, 1'b0);
        expect_px("lz_d1_blank",  142, 101, 1'b0);
        expect_px("lz_d2_4_f",    165, 110, 1'b1);
        expect_px("lz_d2_4_a",    174, 101, 1'b0);
        expect_px("lz_d3_0_a",    206, 101, 1'b1);
        value = 16'h0000;
        pulse_fs();
        expect_px("lz0_d2_blank", 174, 101, 1'b0);
        expect_px("lz0_d3_a",     206, 101, 1'b1);
        value = 16'h0A05;
        pulse_fs();
        expect_px("lzm_d0_blank", 110, 101, 1'b0);
        expect_px("lzm_d1_minus", 142, 121, 1'b1);
        expect_px("lzm_d2_zero",  174, 101, 1'b1);
        blank_lz = 1'b0;

        // Frame latching
        value = 16'h1234;
        pulse_fs();
        expect_px("latch_1_b", 122, 110, 1'b1);
        value = 16'h5678;
        expect_px("latch_1_a_hold", 110, 101, 1'b0);
        expect_px("latch_4_a_hold", 206, 101, 1'b0);
        pulse_fs();
        expect_px("latch_5_a", 110, 101, 1'b1);
        expect_px("latch_5_b", 122, 110, 1'b0);
        expect_px("latch_8_a", 206, 101, 1'b1);

        // Latency and valid
        fg = 12'hFFF;
        value = 16'h8888;
        pulse_fs();
        @(posedge clk); @(posedge clk); #1;
        h_cnt = 10'd110; v_cnt = 10'd100; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        check("lat_c1", {20'd0, hit, pixel_out}, 32'd0);
        @(posedge clk); #1;
        check("lat_c2", {20'd0, hit, pixel_out}, {20'd0, 1'b1, 12'hFFF});
        @(posedge clk); #1;
        check("lat_c3", {20'd0, hit, pixel_out}, 32'd0);
        h_cnt = 10'd110; v_cnt = 10'd101;
        @(posedge clk); @(posedge clk); #1;
        check("valid0", {20'd0, hit, pixel_out}, 32'd0);

        // Geometry boundaries on digit 0 ("8")
        expect_px("edge_b_last_col", 123, 110, 1'b1);
        expect_px("edge_gap",        124, 110, 1'b0);
        expect_px("edge_left_out",    99, 110, 1'b0);
        expect_px("edge_corner_bl",  100, 143, 1'b0);
        expect_px("edge_d_last_row", 110, 143, 1'b1);
        expect_px("edge_below",      110, 144, 1'b0);
        expect_px("edge_far",         50,  50, 1'b0);

        // Reset asserted mid-frame
        h_cnt = 10'd110; v_cnt = 10'd101; valid = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check("mid_pre_rst", {20'd0, hit, pixel_out}, {20'd0, 1'b1, 12'hFFF});
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst", {20'd0, hit, pixel_out}, 32'd0);
        valid = 1'b0;
        rst = 1'b0;

        // Blink: BLINK_FRAMES=2, digit 3 blinks (blink_en bit 3)
        value = 16'h8888; blink_en = 4'b1000;
        for (int f = 0; f < 6; f++) begin
            pulse_fs();
            expect_px($sformatf("blink_f%0d_d3", f + 1), 206, 101, blink_vis[f]);
            expect_px($sformatf("blink_f%0d_d0", f + 1), 110, 101, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
